// File: rtl/vram_write_sequencer.sv
// vram_write_sequencer
// Queues HPS-side VRAM write commands in a small FIFO and drains them onto
// the PPU write port, one per cycle, whenever a write window opens.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a write-window IRQ with work queued
// ST_DRAIN | popping one command per cycle until empty, burst limit or
//          | early window close
module vram_write_sequencer #(
  parameter int                ADDR_W    = 13,
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 16,
  parameter int                MAX_BURST = 16,
  parameter logic [ADDR_W-1:0] ADDR_MAX  = 'h1A27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [DATA_W/8-1:0]      cmd_byteena,
  input  logic                     wr_irq,
  input  logic                     wr_window_end,
  input  logic                     err_clear,
  output logic [ADDR_W-1:0]        vram_wraddr,
  output logic                     vram_wren,
  output logic [DATA_W-1:0]        vram_wrdata,
  output logic [DATA_W/8-1:0]      vram_byteena,
  output logic                     wr_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     addr_err
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int BE_W = DATA_W / 8;
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int EW   = ADDR_W + DATA_W + BE_W;

  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [0:0]        state;
  logic [BW-1:0]     burst_cnt;

  logic              push;
  logic              pop;
  logic              head_ok;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;

  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign cmd_ready  = (count != CNT_FULL);
  assign fifo_count = count;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == ST_DRAIN) && !wr_window_end && (count != '0);

  assign {head_addr, head_data, head_be} = mem[rd_ptr];
  assign head_ok = (head_addr <= ADDR_MAX);

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_addr, cmd_data, cmd_byteena};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain FSM and burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_irq && (count != '0) && !wr_window_end) begin
            state     <= ST_DRAIN;
            burst_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (wr_window_end) begin
            state <= ST_IDLE;
          end else if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
            // A simultaneous push keeps the FIFO non-empty, so the burst goes on.
            if (((count == CNT_ONE) && !push) || (burst_cnt == BURST_LAST)) begin
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register each popped entry onto the VRAM port; busy tracks issued slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_wraddr  <= '0;
      vram_wrdata  <= '0;
      vram_byteena <= '0;
      vram_wren    <= 1'b0;
      wr_busy      <= 1'b0;
    end else begin
      vram_wren <= pop && head_ok;
      wr_busy   <= pop;
      if (pop) begin
        vram_wraddr  <= head_addr;
        vram_wrdata  <= head_data;
        vram_byteena <= head_be;
      end
    end
  end

  // Sticky out-of-range flag; a new discard wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (pop && !head_ok) begin
      addr_err <= 1'b1;
    end else if (err_clear) begin
      addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_sequencer.sv
// Directed bench for vram_write_sequencer: default instance plus a
// MAX_BURST=4 instance sharing the same stimulus.
module tb_vram_write_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [7:0]  cmd_byteena = '0;
  logic        wr_irq = 1'b0;
  logic        wr_window_end = 1'b0;
  logic        err_clear = 1'b0;

  logic        cmd_ready, vram_wren, wr_busy, addr_err;
  logic [12:0] vram_wraddr;
  logic [63:0] vram_wrdata;
  logic [7:0]  vram_byteena;
  logic [4:0]  fifo_count;

  logic        cmd_ready_4, vram_wren_4, wr_busy_4, addr_err_4;
  logic [12:0] vram_wraddr_4;
  logic [63:0] vram_wrdata_4;
  logic [7:0]  vram_byteena_4;
  logic [4:0]  fifo_count_4;

  vram_write_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_byteena(cmd_byteena),
    .wr_irq(wr_irq), .wr_window_end(wr_window_end), .err_clear(err_clear),
    .vram_wraddr(vram_wraddr), .vram_wren(vram_wren), .vram_wrdata(vram_wrdata),
    .vram_byteena(vram_byteena), .wr_busy(wr_busy), .fifo_count(fifo_count),
    .addr_err(addr_err)
  );

  vram_write_sequencer #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_byteena(cmd_byteena),
    .wr_irq(wr_irq), .wr_window_end(wr_window_end), .err_clear(err_clear),
    .vram_wraddr(vram_wraddr_4), .vram_wren(vram_wren_4), .vram_wrdata(vram_wrdata_4),
    .vram_byteena(vram_byteena_4), .wr_busy(wr_busy_4), .fifo_count(fifo_count_4),
    .addr_err(addr_err_4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        wren_log  [32];
  logic [12:0] addr_log  [32];
  logic        busy_log  [32];
  logic        err_log   [32];
  logic        wren4_log [32];
  logic [12:0] addr4_log [32];

  logic [12:0] nom_addr [8] = '{13'h0000, 13'h07FF, 13'h0800, 13'h17FF,
                                13'h1800, 13'h19FF, 13'h1A00, 13'h1A27};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_cmd(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
    cmd_valid   = 1'b1;
    cmd_addr    = a;
    cmd_data    = d;
    cmd_byteena = be;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic pulse_irq();
    wr_irq = 1'b1;
    tick();
    wr_irq = 1'b0;
  endtask

  // Log outputs once per cycle; end_idx selects which edge samples wr_window_end.
  task automatic collect(input int n, input int end_idx);
    for (int k = 0; k < n; k++) begin
      wr_window_end = (k == end_idx);
      tick();
      wr_window_end = 1'b0;
      wren_log[k]  = vram_wren;
      addr_log[k]  = vram_wraddr;
      busy_log[k]  = wr_busy;
      err_log[k]   = addr_err;
      wren4_log[k] = vram_wren_4;
      addr4_log[k] = vram_wraddr_4;
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wren", vram_wren, 0);
    chk("rst_busy", wr_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_addr", vram_wraddr, 0);
    chk("rst_data", vram_wrdata, 0);
    chk("rst_be", vram_byteena, 0);

    // Nominal 8-write burst
    for (int i = 0; i < 8; i++) push_cmd(nom_addr[i], 64'h12345, 8'hFF);
    chk("nom_count_q", fifo_count, 8);
    pulse_irq();
    chk("nom_busy_pre", wr_busy, 0);
    chk("nom_wren_pre", vram_wren, 0);
    collect(10, -1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("nom_wren%0d", i), wren_log[i], 1);
      chk($sformatf("nom_addr%0d", i), addr_log[i], nom_addr[i]);
      chk($sformatf("nom_busy%0d", i), busy_log[i], 1);
    end
    chk("nom_wren_end", wren_log[8], 0);
    chk("nom_busy_end", busy_log[8], 0);
    chk("nom_wren_end2", wren_log[9], 0);
    chk("nom_data", vram_wrdata, 64'h12345);
    chk("nom_be", vram_byteena, 8'hFF);
    chk("nom_count", fifo_count, 0);
    chk("nom_err", addr_err, 0);

    // Burst limit on the MAX_BURST=4 instance
    do_reset();
    for (int i = 0; i < 6; i++) push_cmd(13'h10 + 13'(i), 64'(i), 8'h0F);
    pulse_irq();
    collect(6, -1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lim_wren%0d", i), wren4_log[i], 1);
      chk($sformatf("lim_addr%0d", i), addr4_log[i], 13'h10 + 13'(i));
    end
    chk("lim_stop", wren4_log[4], 0);
    chk("lim_count", fifo_count_4, 2);
    chk("lim_full16_count", fifo_count, 0);
    pulse_irq();
    collect(4, -1);
    chk("lim2_wren0", wren4_log[0], 1);
    chk("lim2_addr0", addr4_log[0], 13'h14);
    chk("lim2_wren1", wren4_log[1], 1);
    chk("lim2_addr1", addr4_log[1], 13'h15);
    chk("lim2_stop", wren4_log[2], 0);
    chk("lim2_count", fifo_count_4, 0);
    chk("lim2_empty_irq", busy_log[0], 0);

    // Early close on the 4th DRAIN cycle
    do_reset();
    for (int i = 0; i < 10; i++) push_cmd(13'h20 + 13'(i), 64'hA0 + 64'(i), 8'hFF);
    pulse_irq();
    collect(5, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ec_wren%0d", i), wren_log[i], 1);
      chk($sformatf("ec_addr%0d", i), addr_log[i], 13'h20 + 13'(i));
    end
    chk("ec_wren3", wren_log[3], 0);
    chk("ec_busy3", busy_log[3], 0);
    chk("ec_wren4", wren_log[4], 0);
    chk("ec_count", fifo_count, 7);

    // Full FIFO, rejected push, push+pop during DRAIN
    do_reset();
    for (int i = 0; i < 16; i++) push_cmd(13'(i), 64'(i), 8'h01);
    chk("full_ready", cmd_ready, 0);
    chk("full_count", fifo_count, 16);
    push_cmd(13'h1F, 64'h1F, 8'h01);
    chk("full_reject", fifo_count, 16);
    pulse_irq();
    cmd_valid = 1'b1;
    cmd_addr  = 13'h40;
    tick();
    chk("full_nobypass", fifo_count, 15);
    chk("full_ready2", cmd_ready, 1);
    cmd_addr = 13'h41;
    tick();
    cmd_valid = 1'b0;
    chk("full_pushpop", fifo_count, 15);
    collect(16, -1);
    chk("full_last_wren", wren_log[13], 1);
    chk("full_last_addr", addr_log[13], 13'h0F);
    chk("full_burst_stop", wren_log[14], 0);
    chk("full_left", fifo_count, 1);

    // Out-of-range address
    do_reset();
    push_cmd(13'h0000, 64'h1, 8'hFF);
    push_cmd(13'h1A28, 64'h2, 8'hFF);
    push_cmd(13'h0001, 64'h3, 8'hFF);
    pulse_irq();
    collect(5, -1);
    chk("oor_wren0", wren_log[0], 1);
    chk("oor_wren1", wren_log[1], 0);
    chk("oor_wren2", wren_log[2], 1);
    chk("oor_addr2", addr_log[2], 13'h0001);
    chk("oor_busy1", busy_log[1], 1);
    chk("oor_busy3", busy_log[3], 0);
    chk("oor_err0", err_log[0], 0);
    chk("oor_err1", err_log[1], 1);
    chk("oor_err_sticky", err_log[4], 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("oor_clear", addr_err, 0);

    // Reset mid-drain, then IRQ with empty FIFO
    do_reset();
    for (int i = 0; i < 8; i++) push_cmd(nom_addr[i], 64'h55, 8'hFF);
    pulse_irq();
    tick();
    chk("rmd_w1", vram_wren, 1);
    tick();
    chk("rmd_w2", vram_wren, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmd_wren", vram_wren, 0);
    chk("rmd_count", fifo_count, 0);
    chk("rmd_busy", wr_busy, 0);
    pulse_irq();
    collect(3, -1);
    chk("empty_irq_busy0", busy_log[0], 0);
    chk("empty_irq_busy1", busy_log[1], 0);
    chk("empty_irq_wren", wren_log[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
